seq_decoder_n: RTL and testbench
================================

# seq_decoder_n

Registered, parametrised N-to-2^N one-hot decoder with a valid/ready handshake on both sides and a built-in scan mode. In scan mode the block walks a single hot bit across all outputs at a programmable rate. It is the sequential successor to the team's fixed 3-to-8 combinational decoder. It sits between a select-producing controller and downstream enable/strobe consumers, such as bank, LED or mux selects, that may apply backpressure.

## Interface
Parameters:
- N, 3, select width; output width M = 2**N (localparam, not overridable)
- SCAN_DIV, 4, cycles per scan step; legal range 1..2**16, counter width $clog2(SCAN_DIV+1)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- en  in  1  block enable; 0 blocks new accepts and scan steps, but a held output still drains
- mode  in  1  0 = DECODE, 1 = SCAN
- a  in  N  select value
- in_valid  in  1  a is valid
- in_ready  out  1  block accepts a this cycle
- y  out  M  registered one-hot output; all-zero when y_valid = 0
- y_valid  out  1  y is valid
- y_ready  in  1  downstream accepts y
- idx  out  N  index of the current or last hot bit

## Operation
- The FSM has two states, S_DEC and S_SCAN; reset state is S_DEC.
- Output register: one stage. A slot is free when !y_valid || y_ready.
- in_ready = !rst && en && state == S_DEC && mode == 0 && slot free. This signal is combinational and has no dependency on in_valid.
- DECODE accept (in_valid && in_ready): next cycle y = 1 << a, y_valid = 1, idx = a.
- Drain: when y_valid && y_ready and nothing new is loaded, y is cleared to 0 next cycle and y_valid goes to 0.
- Stall: when y_valid && !y_ready, y, y_valid and idx are held stable.
- Scan divider: div counts 0..SCAN_DIV-1 while state == S_SCAN && en.
  - At div == SCAN_DIV-1 with a free slot: load y = 1 << scan_ptr, set y_valid = 1, idx = scan_ptr, then scan_ptr++ (wraps 2^N-1 -> 0) and div resets to 0.
  - At terminal count with no free slot: div holds at terminal count. No index is ever skipped.
- Mode transitions take effect only when the output register is empty (y_valid = 0) or draining (y_ready = 1) this cycle.
  - S_DEC -> S_SCAN when mode = 1: div and scan_ptr are set to 0.
  - S_SCAN -> S_DEC when mode = 0: div and scan_ptr are frozen, and scan restarts from 0 on the next entry.
- en = 0: no accepts and no div advance (div holds); a held y drains normally.
- Simultaneous drain and load: the new value wins and y_valid stays 1, giving full throughput of 1 item per cycle.

## Timing
- Reset (async assert; deassert synchronous to clk per the team flow): y = 0, y_valid = 0, idx = 0, in_ready = 0, div = 0, scan_ptr = 0, state = S_DEC.
- DECODE latency: accept at edge k gives y_valid = 1 after edge k.
- DECODE throughput: 1 per cycle with y_ready held at 1.
- SCAN: the first y_valid appears SCAN_DIV cycles after the mode-change edge. In steady state with no backpressure there is one pulse every SCAN_DIV cycles.
- SCAN_DIV = 1: y_valid stays continuously high and a new index is presented each cycle.
- rst mid-transfer: the held y is discarded and does not complete; all outputs return to their reset values immediately.

## Structure
- Package seq_decoder_pkg holds:
  - state_t enum {S_DEC, S_SCAN}
  - MODE_DECODE = 1'b0, MODE_SCAN = 1'b1
- Sub-module onehot_dec #(N) is a purely combinational N -> 2^N decode. It is instanced once, fed by a mux of a and scan_ptr.
- The output register, FSM and divider live in the top module.

## Test plan
- Reset, then DECODE sweep of a = 0..7 with in_valid = 1 and y_ready = 1 -> y = 0x01, 0x02 … 0x80 on consecutive cycles, y_valid high for 8 cycles, then y = 0.
- DECODE with a = 5 while y_ready = 0 for 4 cycles -> y = 0x20 held, in_ready = 0 throughout; on the y_ready edge, y_valid drops.
- SCAN with SCAN_DIV = 4, N = 3, y_ready = 1 -> hot bit 0,1,…,7,0 every 4 cycles; idx wraps 7 -> 0.
- SCAN with y_ready low for 10 cycles at idx 3 -> y = 0x08 held; after release, next is idx 4 (no skips); div is held at 3 during the stall.
- mode toggled to 0 while y is stalled -> state stays S_SCAN until drain, then in_ready rises. rst asserted mid-stall -> y = 0, y_valid = 0 asynchronously.
- en = 0 in SCAN for 6 cycles -> no pulses and div frozen; resumes from the same div value.

Source files
------------

// File: rtl/seq_decoder_pkg.sv
// Shared types and constants for the sequential one-hot decoder.
package seq_decoder_pkg;

   typedef enum logic {
      S_DEC  = 1'b0,
      S_SCAN = 1'b1
   } state_t;

   localparam logic MODE_DECODE = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/seq_decoder_n_onehot_dec.sv
// Purely combinational N -> 2^N one-hot decode.
module onehot_dec #(
   parameter  int N = 3,
   localparam int M = 2**N
) (
   input  logic [N-1:0] sel,
   output logic [M-1:0] y
);

   // Drive exactly one bit high, selected by sel.
   always_comb begin
      y      = '0;
      y[sel] = 1'b1;
   end

endmodule

// File: rtl/seq_decoder_n.sv
// Registered N-to-2^N one-hot decoder with valid/ready on both sides and a
// scan mode that walks a single hot bit across all outputs every SCAN_DIV cycles.
module seq_decoder_n
   import seq_decoder_pkg::*;
#(
   parameter  int N        = 3,
   parameter  int SCAN_DIV = 4,
   localparam int M        = 2**N
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         mode,
   input  logic [N-1:0] a,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [M-1:0] y,
   output logic         y_valid,
   input  logic         y_ready,
   output logic [N-1:0] idx
);

   localparam int               DIV_W  = $clog2(SCAN_DIV + 1);
   localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(SCAN_DIV - 1);

   state_t           state_q;
   state_t           state_d;
   logic [DIV_W-1:0] div_q;
   logic [N-1:0]     ptr_q;

   logic [M-1:0]     y_p1;
   logic             vld_p1;
   logic [N-1:0]     idx_p1;

   logic             slot_free;
   logic             in_ready_c;
   logic             accept;
   logic             scan_run;
   logic             div_tc;
   logic             scan_step;
   logic             enter_scan;
   logic             load;
   logic [N-1:0]     dec_sel;
   logic [M-1:0]     dec_y;

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_DEC;
      else     state_q <= state_d;
   end

   // Mode changes only when the output register is empty or draining this cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_DEC:   if (mode == MODE_SCAN   && slot_free) state_d = S_SCAN;
         S_SCAN:  if (mode == MODE_DECODE && slot_free) state_d = S_DEC;
         default: state_d = S_DEC;
      endcase
   end

   // Handshake and scan-step control derived from state, divider and slot.
   always_comb begin
      slot_free  = !vld_p1 || y_ready;
      in_ready_c = !rst && en && (state_q == S_DEC) && (mode == MODE_DECODE) && slot_free;
      accept     = in_valid && in_ready_c;
      // The divider only runs while scan is being requested; a pending exit freezes it.
      scan_run   = (state_q == S_SCAN) && (mode == MODE_SCAN) && en;
      div_tc     = (div_q == DIV_TC);
      scan_step  = scan_run && div_tc && slot_free;
      enter_scan = (state_q == S_DEC) && (state_d == S_SCAN);
      load       = accept || scan_step;
      dec_sel    = (state_q == S_SCAN) ? ptr_q : a;
   end

   onehot_dec #(.N(N)) u_dec (
      .sel (dec_sel),
      .y   (dec_y)
   );

   // Scan divider and pointer; at terminal count with a blocked slot, div holds so no index is skipped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q <= '0;
         ptr_q <= '0;
      end else if (enter_scan) begin
         div_q <= '0;
         ptr_q <= '0;
      end else if (scan_run) begin
         if (div_tc) begin
            if (slot_free) begin
               div_q <= '0;
               ptr_q <= ptr_q + N'(1);
            end
         end else begin
            div_q <= div_q + DIV_W'(1);
         end
      end
   end

   // Output stage: a new load wins over a drain; a stalled value is held.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         y_p1   <= '0;
         vld_p1 <= 1'b0;
         idx_p1 <= '0;
      end else if (load) begin
         y_p1   <= dec_y;
         vld_p1 <= 1'b1;
         idx_p1 <= dec_sel;
      end else if (vld_p1 && y_ready) begin
         y_p1   <= '0;
         vld_p1 <= 1'b0;
      end
   end

   assign in_ready = in_ready_c;
   assign y        = y_p1;
   assign y_valid  = vld_p1;
   assign idx      = idx_p1;

endmodule

// File: tb/tb_seq_decoder_n.sv
// Directed testbench for seq_decoder_n (N = 3, SCAN_DIV = 4).
module tb_seq_decoder_n;

   localparam int N = 3;
   localparam int M = 8;
   localparam int SCAN_DIV = 4;

   logic         clk;
   logic         rst;
   logic         en;
   logic         mode;
   logic [N-1:0] a;
   logic         in_valid;
   logic         in_ready;
   logic [M-1:0] y;
   logic         y_valid;
   logic         y_ready;
   logic [N-1:0] idx;

   int checks = 0;
   int errors = 0;

   seq_decoder_n #(.N(N), .SCAN_DIV(SCAN_DIV)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .mode     (mode),
      .a        (a),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .y        (y),
      .y_valid  (y_valid),
      .y_ready  (y_ready),
      .idx      (idx)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   task automatic enter_scan();
      y_ready = 1'b1;
      mode    = 1'b0;
      repeat (2) @(negedge clk);
      mode = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b0; mode = 1'b0; a = '0; in_valid = 1'b0; y_ready = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (y !== 8'h00) begin errors++; $display("FAIL reset_y got %h exp %h", y, 8'h00); end
      checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL reset_y_valid got %b exp 0", y_valid); end
      checks++; if (idx !== 3'd0) begin errors++; $display("FAIL reset_idx got %0d exp 0", idx); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
      rst = 1'b0; en = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %b exp 1", in_ready); end
   endtask

   task automatic test_decode_sweep();
      logic [M-1:0] e;
      y_ready = 1'b1; mode = 1'b0;
      for (int i = 0; i < 8; i++) begin
         a = N'(i); in_valid = 1'b1;
         @(negedge clk);
         e = 8'h01 << i;
         checks++; if (y !== e) begin errors++; $display("FAIL sweep_y[%0d] got %h exp %h", i, y, e); end
         checks++; if (y_valid !== 1'b1) begin errors++; $display("FAIL sweep_valid[%0d] got %b exp 1", i, y_valid); end
         checks++; if (idx !== N'(i)) begin errors++; $display("FAIL sweep_idx[%0d] got %0d exp %0d", i, idx, i); end
      end
      in_valid = 1'b0;
      @(negedge clk);
      checks++; if (y !== 8'h00) begin errors++; $display("FAIL sweep_drain_y got %h exp 00", y); end
      checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL sweep_drain_valid got %b exp 0", y_valid); end
      checks++; if (idx !== 3'd7) begin errors++; $display("FAIL sweep_last_idx got %0d exp 7", idx); end
   endtask

   task automatic test_stall();
      a = 3'd5; in_valid = 1'b1; y_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (y !== 8'h20) begin errors++; $display("FAIL stall_load_y got %h exp 20", y); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_load_ready got %b exp 0", in_ready); end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++; if (y !== 8'h20 || y_valid !== 1'b1) begin errors++; $display("FAIL stall_hold[%0d] got y=%h v=%b exp y=20 v=1", i, y, y_valid); end
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready[%0d] got %b exp 0", i, in_ready); end
      end
      y_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready got %b exp 1", in_ready); end
      @(negedge clk);
      checks++; if (y_valid !== 1'b0 || y !== 8'h00) begin errors++; $display("FAIL stall_drain got y=%h v=%b exp y=00 v=0", y, y_valid); end
   endtask

   task automatic test_scan();
      logic [M-1:0] e;
      enter_scan();
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL scan_in_ready got %b exp 0", in_ready); end
      for (int k = 0; k < 9; k++) begin
         for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL scan_gap[%0d.%0d] got %b exp 0", k, j, y_valid); end
         end
         @(negedge clk);
         e = 8'h01 << (k % 8);
         checks++; if (y_valid !== 1'b1 || y !== e) begin errors++; $display("FAIL scan_pulse[%0d] got y=%h v=%b exp y=%h v=1", k, y, y_valid, e); end
         checks++; if (idx !== N'(k % 8)) begin errors++; $display("FAIL scan_idx[%0d] got %0d exp %0d", k, idx, k % 8); end
      end
   endtask

   task automatic test_scan_stall();
      enter_scan();
      repeat (15) @(negedge clk);
      y_ready = 1'b0;
      @(negedge clk);
      checks++; if (y !== 8'h08 || y_valid !== 1'b1 || idx !== 3'd3) begin errors++; $display("FAIL sstall_load got y=%h v=%b i=%0d exp y=08 v=1 i=3", y, y_valid, idx); end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++; if (y !== 8'h08 || y_valid !== 1'b1 || idx !== 3'd3) begin errors++; $display("FAIL sstall_hold[%0d] got y=%h v=%b i=%0d exp y=08 v=1 i=3", i, y, y_valid, idx); end
      end
      checks++; if (dut.div_q !== 3'd3) begin errors++; $display("FAIL sstall_div got %0d exp 3", dut.div_q); end
      y_ready = 1'b1;
      @(negedge clk);
      checks++; if (y !== 8'h10 || y_valid !== 1'b1 || idx !== 3'd4) begin errors++; $display("FAIL sstall_next got y=%h v=%b i=%0d exp y=10 v=1 i=4", y, y_valid, idx); end
   endtask

   task automatic test_mode_toggle_and_rst();
      y_ready = 1'b0; mode = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++; if (y !== 8'h10 || y_valid !== 1'b1) begin errors++; $display("FAIL toggle_hold[%0d] got y=%h v=%b exp y=10 v=1", i, y, y_valid); end
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL toggle_ready[%0d] got %b exp 0", i, in_ready); end
      end
      y_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL toggle_still_scan got %b exp 0", in_ready); end
      @(negedge clk);
      checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL toggle_drain got %b exp 0", y_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL toggle_ready_up got %b exp 1", in_ready); end
      a = 3'd2; in_valid = 1'b1; y_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (y !== 8'h04 || y_valid !== 1'b1) begin errors++; $display("FAIL rst_pre got y=%h v=%b exp y=04 v=1", y, y_valid); end
      #2 rst = 1'b1;
      #1;
      checks++; if (y !== 8'h00 || y_valid !== 1'b0) begin errors++; $display("FAIL rst_async got y=%h v=%b exp y=00 v=0", y, y_valid); end
      checks++; if (idx !== 3'd0 || in_ready !== 1'b0) begin errors++; $display("FAIL rst_async_ctl got i=%0d r=%b exp i=0 r=0", idx, in_ready); end
      @(negedge clk);
      rst = 1'b0; y_ready = 1'b1;
   endtask

   task automatic test_en();
      enter_scan();
      repeat (2) @(negedge clk);
      en = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL en_nopulse[%0d] got %b exp 0", i, y_valid); end
      end
      checks++; if (dut.div_q !== 3'd2) begin errors++; $display("FAIL en_div_frozen got %0d exp 2", dut.div_q); end
      en = 1'b1;
      @(negedge clk);
      checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL en_resume_gap got %b exp 0", y_valid); end
      @(negedge clk);
      checks++; if (y_valid !== 1'b1 || y !== 8'h01 || idx !== 3'd0) begin errors++; $display("FAIL en_resume_pulse got y=%h v=%b i=%0d exp y=01 v=1 i=0", y, y_valid, idx); end
      mode = 1'b0;
      repeat (2) @(negedge clk);
      en = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL en_dec_block got %b exp 0", in_ready); end
      en = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL en_dec_ready got %b exp 1", in_ready); end
   endtask

   initial begin
      test_reset();
      test_decode_sweep();
      test_stall();
      test_scan();
      test_scan_stall();
      test_mode_toggle_and_rst();
      test_en();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
